// File: rtl/sad_csa_accum_ctrl.sv
// sad_csa_accum_ctrl: block SAD accumulator, carry-save row per pair, one carry-propagate add per block
module compressor_3_2 (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module sad_csa_accum_ctrl #(
  parameter int PIX_W = 8,
  parameter int BLK_N = 16,
  parameter int ACC_W = 12,
  localparam int CNT_W = $clog2(BLK_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] cur_pix,
  input  logic [PIX_W-1:0] ref_pix,
  output logic             sad_valid,
  input  logic             sad_ready,
  output logic [ACC_W-1:0] sad,
  output logic [CNT_W-1:0] pix_cnt
);
  typedef enum logic [1:0] {ACCUM, RESOLVE, DONE} state_t;
  state_t state, state_nx;
  logic [PIX_W-1:0] diff;
  logic [ACC_W-1:0] d, sum_r, carry_r, cshift, row_s, row_c;
  logic accept, last;

  assign diff   = (cur_pix > ref_pix) ? cur_pix - ref_pix : ref_pix - cur_pix;
  assign d      = {{(ACC_W-PIX_W){1'b0}}, diff};
  assign cshift = {carry_r[ACC_W-2:0], 1'b0};
  assign last   = pix_cnt == CNT_W'(BLK_N - 1);

  for (genvar g = 0; g < ACC_W; g++) begin : g_row
    compressor_3_2 u_c (.a(d[g]), .b(sum_r[g]), .c(cshift[g]), .s(row_s[g]), .co(row_c[g]));
  end

  // The carry MSB would weigh 2^ACC_W; the width bound keeps it zero.
  always_comb assert (rst || !carry_r[ACC_W-1]);

  always_comb begin
    in_ready  = state == ACCUM;
    sad_valid = state == DONE;
    accept    = in_valid && in_ready && !abort;
    state_nx  = abort ? ACCUM :
                state == ACCUM ? ((accept && last) ? RESOLVE : ACCUM) :
                state == RESOLVE ? DONE :
                sad_ready ? ACCUM : DONE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ACCUM;
    else     state <= state_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_r   <= '0;
      carry_r <= '0;
      pix_cnt <= '0;
      sad     <= '0;
    end else if (abort) begin
      sum_r   <= '0;
      carry_r <= '0;
      pix_cnt <= '0;
    end else if (accept) begin
      sum_r   <= row_s;
      carry_r <= row_c;
      pix_cnt <= pix_cnt + 1'b1;
    end else if (state == RESOLVE) begin
      sad <= sum_r + cshift;
    end else if (sad_valid && sad_ready) begin
      sum_r   <= '0;
      carry_r <= '0;
    end
  end
endmodule

// File: tb/tb_sad_csa_accum_ctrl.sv
// tb_sad_csa_accum_ctrl: directed vectors for the SAD controller at BLK_N=16 and BLK_N=4
module tb_sad_csa_accum_ctrl;
  logic clk, rst, abort, in_valid, sad_ready;
  logic [7:0] cur_pix, ref_pix;
  logic in_ready, sad_valid, in_ready4, sad_valid4;
  logic [11:0] sad;
  logic [3:0] pix_cnt;
  logic [9:0] sad4;
  logic [1:0] pix_cnt4;
  int vecs, errs;

  typedef struct {
    logic [7:0]  c;
    logic [7:0]  r;
    logic [11:0] exp;
    bit          gaps;
  } vec_t;
  vec_t tbl[7];

  sad_csa_accum_ctrl dut (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .cur_pix(cur_pix), .ref_pix(ref_pix), .sad_valid(sad_valid), .sad_ready(sad_ready),
    .sad(sad), .pix_cnt(pix_cnt)
  );

  sad_csa_accum_ctrl #(.PIX_W(8), .BLK_N(4), .ACC_W(10)) dut4 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(in_ready4),
    .cur_pix(cur_pix), .ref_pix(ref_pix), .sad_valid(sad_valid4), .sad_ready(sad_ready),
    .sad(sad4), .pix_cnt(pix_cnt4)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] c, input logic [7:0] r);
    int n = 0;
    cur_pix  = c;
    ref_pix  = r;
    in_valid = 1;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready) chk("push_timeout", 0, 1);
    tick();
    in_valid = 0;
  endtask

  task automatic block(input logic [7:0] c, input logic [7:0] r, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      push(c, r);
      chk("pix_cnt", pix_cnt, (i + 1) % 16);
    end
  endtask

  task automatic expect_result(input logic [11:0] exp);
    chk("resolve_in_ready", in_ready, 0);
    chk("resolve_valid", sad_valid, 0);
    tick();
    chk("done_valid", sad_valid, 1);
    chk("sad", sad, exp);
    tick();
    chk("valid_drop", sad_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst = 1; abort = 0; in_valid = 0; sad_ready = 1; cur_pix = 0; ref_pix = 0;
    tbl[0] = '{8'd255, 8'd0,   12'd4080, 1'b0};
    tbl[1] = '{8'd7,   8'd2,   12'd80,   1'b1};
    tbl[2] = '{8'd0,   8'd255, 12'd4080, 1'b1};
    tbl[3] = '{8'd100, 8'd200, 12'd1600, 1'b0};
    tbl[4] = '{8'd3,   8'd3,   12'd0,    1'b1};
    tbl[5] = '{8'd0,   8'd0,   12'd0,    1'b0};
    tbl[6] = '{8'd128, 8'd127, 12'd16,   1'b1};
    tick(); tick();
    chk("rst_sad", sad, 0);
    chk("rst_valid", sad_valid, 0);
    chk("rst_pix_cnt", pix_cnt, 0);
    rst = 0;
    #1;
    chk("rst_in_ready", in_ready, 1);

    push(10, 3); push(3, 10); push(255, 0); push(0, 0);
    chk("b4_resolve_valid", sad_valid4, 0);
    chk("b4_resolve_ready", in_ready4, 0);
    chk("b16_pix_cnt_4", pix_cnt, 4);
    tick();
    chk("b4_valid", sad_valid4, 1);
    chk("b4_sad", sad4, 269);
    tick();
    chk("b4_valid_one_cycle", sad_valid4, 0);
    chk("b4_ready_back", in_ready4, 1);
    rst = 1; tick(); rst = 0;

    for (int i = 0; i < 7; i++) begin
      block(tbl[i].c, tbl[i].r, tbl[i].gaps);
      expect_result(tbl[i].exp);
    end

    sad_ready = 0;
    block(20, 10, 0);
    tick();
    in_valid = 1; cur_pix = 50; ref_pix = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", sad_valid, 1);
      chk("bp_sad", sad, 160);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_pix_cnt", pix_cnt, 0);
      tick();
    end
    sad_ready = 1; in_valid = 0;
    tick();
    chk("bp_release", sad_valid, 0);
    block(3, 0, 0);
    expect_result(48);

    for (int i = 0; i < 9; i++) push(5, 0);
    chk("abort_pre_cnt", pix_cnt, 9);
    abort = 1;
    tick();
    chk("abort_cnt", pix_cnt, 0);
    chk("abort_keeps_sad", sad, 48);
    in_valid = 1; cur_pix = 100; ref_pix = 0;
    tick();
    chk("abort_blocks_accept", pix_cnt, 0);
    abort = 0; in_valid = 0;
    block(1, 0, 0);
    expect_result(16);

    block(255, 0, 0);
    rst = 1;
    #1;
    chk("rst_resolve_valid", sad_valid, 0);
    chk("rst_resolve_sad", sad, 0);
    chk("rst_resolve_ready", in_ready, 1);
    tick(); rst = 0;
    sad_ready = 0;
    block(255, 0, 0);
    tick();
    chk("pre_rst_done_sad", sad, 4080);
    rst = 1;
    #1;
    chk("rst_done_valid", sad_valid, 0);
    chk("rst_done_sad", sad, 0);
    tick(); rst = 0; sad_ready = 1;
    block(7, 2, 1);
    expect_result(80);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
